// File: rtl/noc_router_tile_buf.sv
// Buffered 5-port XY mesh router tile (N,E,S,W,L) with an ALU on the L ejection port.
// FIFO head to output register takes one cycle; in_ready is FIFO-not-full and output registers hold while out_ready is low.
module noc_router_tile_buf #(
   parameter int TILE_X     = 0,
   parameter int TILE_Y     = 0,
   parameter int MESH_X     = 3,
   parameter int MESH_Y     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 64,
   parameter int FLIT_W     = 2*DATA_W+16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5*FLIT_W-1:0] in_flit,
   input  logic [4:0]          in_valid,
   output logic [4:0]          in_ready,
   output logic [5*FLIT_W-1:0] out_flit,
   output logic [4:0]          out_valid,
   input  logic [4:0]          out_ready,
   output logic [31:0]         fwd_count,
   output logic                drop_pulse
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [3:0] TX = 4'(TILE_X);
   localparam logic [3:0] TY = 4'(TILE_Y);

   typedef logic [FLIT_W-1:0] flit_t;

   flit_t         mem_q      [5][FIFO_DEPTH];
   flit_t         mem_d      [5][FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q   [5];
   logic [PW-1:0] rd_ptr_d   [5];
   logic [PW-1:0] wr_ptr_q   [5];
   logic [PW-1:0] wr_ptr_d   [5];
   logic [CW-1:0] cnt_q      [5];
   logic [CW-1:0] cnt_d      [5];
   flit_t         out_flit_q [5];
   flit_t         out_flit_d [5];
   logic [2:0]    rr_q       [5];
   logic [2:0]    rr_d       [5];
   logic [4:0]    out_vld_q, out_vld_d;
   logic [31:0]   fwd_count_q, fwd_count_d;

   flit_t      head  [5];
   logic [3:0] dst_x [5];
   logic [3:0] dst_y [5];
   logic [2:0] route [5];
   logic [2:0] gnt_idx [5];
   logic [4:0] gnt_vld;
   logic [4:0] hvld, full, drop, push, pop;

   function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << b[5:0];
         4'd6:    r = a >> b[5:0];
         4'd7:    r = a * b;
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic flit_t eject(input flit_t f);
      return {f[FLIT_W-1 -: 16], {DATA_W{1'b0}},
              alu(f[2*DATA_W+7 -: 4], f[DATA_W-1:0], f[2*DATA_W-1:DATA_W])};
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] p, input int k);
      int s;
      s = int'(p) + k;
      return 3'(s % 5);
   endfunction

   // Head decode: out-of-mesh heads are discarded and never request an output.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         head[i]  = mem_q[i][rd_ptr_q[i]];
         hvld[i]  = (cnt_q[i] != '0);
         full[i]  = (cnt_q[i] == CW'(FIFO_DEPTH));
         dst_x[i] = head[i][FLIT_W-1 -: 4];
         dst_y[i] = head[i][FLIT_W-5 -: 4];
         drop[i]  = hvld[i] && ((int'(dst_x[i]) >= MESH_X) || (int'(dst_y[i]) >= MESH_Y));
         if (dst_x[i] > TX)      route[i] = 3'd1;
         else if (dst_x[i] < TX) route[i] = 3'd3;
         else if (dst_y[i] > TY) route[i] = 3'd2;
         else if (dst_y[i] < TY) route[i] = 3'd0;
         else                    route[i] = 3'd4;
      end
   end

   always_comb begin
      pop       = drop;
      gnt_vld   = '0;
      out_vld_d = out_vld_q & ~out_ready;
      for (int o = 0; o < 5; o++) begin
         gnt_idx[o]    = '0;
         rr_d[o]       = rr_q[o];
         out_flit_d[o] = out_flit_q[o];
      end
      for (int o = 0; o < 5; o++) begin
         if (!out_vld_q[o] || out_ready[o]) begin
            for (int k = 1; k <= 5; k++) begin
               if (!gnt_vld[o] && hvld[rr_next(rr_q[o], k)] && !drop[rr_next(rr_q[o], k)]
                   && (route[rr_next(rr_q[o], k)] == 3'(o))) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = rr_next(rr_q[o], k);
               end
            end
         end
         if (gnt_vld[o]) begin
            pop[gnt_idx[o]] = 1'b1;
            rr_d[o]         = gnt_idx[o];
            out_vld_d[o]    = 1'b1;
            out_flit_d[o]   = (o == 4) ? eject(head[gnt_idx[o]]) : head[gnt_idx[o]];
         end
      end
   end

   // A full FIFO refuses a push even while it pops, so in_ready never depends on arbitration.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < 5; i++) begin
         push[i]     = in_valid[i] && !full[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = in_flit[i*FLIT_W +: FLIT_W];
            wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
         end
         if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      fwd_count_d = fwd_count_q + 32'($countones(out_vld_q & out_ready));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin
            rd_ptr_q[i]   <= '0;
            wr_ptr_q[i]   <= '0;
            cnt_q[i]      <= '0;
            out_flit_q[i] <= '0;
            rr_q[i]       <= '0;
         end
         out_vld_q   <= '0;
         fwd_count_q <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            rd_ptr_q[i]   <= rd_ptr_d[i];
            wr_ptr_q[i]   <= wr_ptr_d[i];
            cnt_q[i]      <= cnt_d[i];
            out_flit_q[i] <= out_flit_d[i];
            rr_q[i]       <= rr_d[i];
         end
         out_vld_q   <= out_vld_d;
         fwd_count_q <= fwd_count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      for (int o = 0; o < 5; o++) out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
      in_ready   = ~full;
      out_valid  = out_vld_q;
      fwd_count  = fwd_count_q;
      drop_pulse = |drop;
   end

endmodule

// File: tb/tb_noc_router_tile_buf.sv
// Self-checking bench for noc_router_tile_buf at tile (1,1) of a 3x3 mesh: ALU vector table,
// directed latency/backpressure/drop/reset sequences, and scoreboarded random traffic.
module tb_noc_router_tile_buf;
   localparam int DW    = 64;
   localparam int FW    = 2*DW+16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5*FW-1:0] in_flit;
   logic [4:0]    in_valid;
   logic [4:0]    in_ready;
   logic [5*FW-1:0] out_flit;
   logic [4:0]    out_valid;
   logic [4:0]    out_ready;
   logic [31:0]   fwd_count;
   logic          drop_pulse;

   int total = 0;
   int bad   = 0;
   int exp_fwd = 0;
   int pulses  = 0;
   int lseq[$];
   logic [FW-1:0] expq [25][$];

   always #5 clk = ~clk;

   noc_router_tile_buf #(.TILE_X(1), .TILE_Y(1), .MESH_X(3), .MESH_Y(3),
                         .FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
      .out_ready(out_ready), .fwd_count(fwd_count), .drop_pulse(drop_pulse));

   typedef struct {
      int          op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
   } alu_vec_t;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int dx, input int dy, input int op, input int tag,
                                         input logic [63:0] a, input logic [63:0] b);
      return {4'(dx), 4'(dy), 4'(op), 4'(tag), b, a};
   endfunction

   function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a * (64'd1 << b[5:0]);
         6: return a / (64'd1 << b[5:0]);
         7: return a * b;
         default: return a;
      endcase
   endfunction

   // XY route at tile (1,1); -1 means the destination lies outside the 3x3 mesh.
   function automatic int ref_route(input int dx, input int dy);
      if (dx >= 3 || dy >= 3) return -1;
      if (dx > 1) return 1;
      if (dx < 1) return 3;
      if (dy > 1) return 2;
      if (dy < 1) return 0;
      return 4;
   endfunction

   function automatic logic [FW-1:0] ref_out(input int port, input logic [FW-1:0] f);
      logic [FW-1:0] r;
      r = f;
      if (port == 4) r = {f[FW-1 -: 16], 64'd0, ref_alu(int'(f[2*DW+4 +: 4]), f[63:0], f[127:64])};
      return r;
   endfunction

   task automatic set_in(input int i, input logic [FW-1:0] f);
      in_flit[i*FW +: FW] = f;
   endtask

   function automatic logic [FW-1:0] get_out(input int o);
      return out_flit[o*FW +: FW];
   endfunction

   task automatic inject_one(input int port, input logic [FW-1:0] f);
      @(negedge clk);
      set_in(port, f);
      in_valid[port] = 1'b1;
      @(negedge clk);
      in_valid = '0;
   endtask

   task automatic observe();
      logic [FW-1:0] f;
      int t;
      for (int o = 0; o < 5; o++) begin
         if (out_valid[o] && out_ready[o]) begin
            f = get_out(o);
            t = int'(f[2*DW +: 4]);
            if (o == 4) lseq.push_back(t);
            if (t > 4 || expq[o*5+t].size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: out %0d got %h want nothing", o, f);
            end else begin
               chk($sformatf("sb_out%0d_in%0d", o, t), f, expq[o*5+t].pop_front());
            end
         end
      end
      if (drop_pulse) pulses++;
   endtask

   task automatic traffic(input int ncyc, input bit rot);
      int acc[5];
      int dropped;
      int left;
      int mism;
      int dx, dy, r;
      logic [FW-1:0] f;
      dropped = 0;
      pulses  = 0;
      lseq.delete();
      for (int i = 0; i < 5; i++) acc[i] = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         out_ready = rot ? 5'h1F : 5'($urandom) | 5'($urandom);
         for (int i = 0; i < 5; i++) begin
            if (rot) begin
               dx = 1; dy = 1;
               in_valid[i] = (i == 0 || i == 3 || i == 4) && acc[i] < 5;
            end else begin
               dx = int'($urandom_range(0, 3));
               dy = int'($urandom_range(0, 3));
               in_valid[i] = ($urandom_range(0, 2) != 0);
            end
            set_in(i, mk(dx, dy, int'($urandom_range(0, 15)), i, {$urandom, $urandom}, {$urandom, $urandom}));
         end
         #1;
         observe();
         for (int i = 0; i < 5; i++) begin
            if (in_valid[i] && in_ready[i]) begin
               acc[i]++;
               f = in_flit[i*FW +: FW];
               r = ref_route(int'(f[FW-1 -: 4]), int'(f[FW-5 -: 4]));
               if (r < 0) dropped++;
               else begin
                  expq[r*5+i].push_back(ref_out(r, f));
                  exp_fwd++;
               end
            end
         end
      end
      @(negedge clk);
      in_valid  = '0;
      out_ready = 5'h1F;
      for (int c = 0; c < 60; c++) begin
         #1;
         observe();
         @(negedge clk);
      end
      left = 0;
      for (int q = 0; q < 25; q++) left += expq[q].size();
      chk(rot ? "rot_none_lost" : "rnd_none_lost", FW'(left), FW'(0));
      chk(rot ? "rot_fwd_count" : "rnd_fwd_count", FW'(fwd_count), FW'(exp_fwd));
      if (rot) begin
         mism = 0;
         for (int k = 0; k < lseq.size(); k++)
            if (lseq[k] != ((k % 3 == 0) ? 3 : (k % 3 == 1) ? 4 : 0)) mism++;
         chk("rot_l_count", FW'(lseq.size()), FW'(15));
         chk("rot_order", FW'(mism), FW'(0));
      end else begin
         chk("rnd_drop_seen", FW'(pulses > 0), FW'(dropped > 0));
      end
   endtask

   initial begin
      alu_vec_t vecs[11];
      logic [FW-1:0] f;
      int acc;
      int n;
      int stale;

      vecs[0]  = '{7,  64'd3, 64'd5, 64'd15};
      vecs[1]  = '{0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
      vecs[2]  = '{1,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[3]  = '{2,  64'hF0F0, 64'hFF00, 64'hF000};
      vecs[4]  = '{3,  64'hF0F0, 64'h0F0F, 64'hFFFF};
      vecs[5]  = '{4,  64'hFF00, 64'h0FF0, 64'hF0F0};
      vecs[6]  = '{5,  64'd1, 64'h43, 64'd8};
      vecs[7]  = '{6,  64'h8000_0000_0000_0000, 64'd63, 64'd1};
      vecs[8]  = '{7,  64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
      vecs[9]  = '{9,  64'hDEAD, 64'h1234, 64'hDEAD};
      vecs[10] = '{15, 64'd7, 64'd9, 64'd7};

      rst_n     = 1'b0;
      in_valid  = '0;
      in_flit   = '0;
      out_ready = 5'h1F;
      #12;
      chk("rst_out_valid", FW'(out_valid), FW'(0));
      chk("rst_in_ready", FW'(in_ready), FW'(5'h1F));
      chk("rst_fwd_count", FW'(fwd_count), FW'(0));
      chk("rst_drop", FW'(drop_pulse), FW'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // W -> E, one cycle after acceptance, bit-exact
      f = mk(2, 1, 3, 5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      inject_one(3, f);
      #1;
      chk("lat_not_early", FW'(out_valid), FW'(0));
      @(negedge clk);
      #1;
      chk("we_valid", FW'(out_valid), FW'(5'b00010));
      chk("we_flit", get_out(1), f);
      @(negedge clk);
      #1;
      exp_fwd = 1;
      chk("we_fwd_count", FW'(fwd_count), FW'(1));
      chk("we_idle", FW'(out_valid), FW'(0));

      // ALU on the L ejection path
      for (int v = 0; v < 11; v++) begin
         f = mk(1, 1, vecs[v].op, 0, vecs[v].a, vecs[v].b);
         inject_one(4, f);
         @(negedge clk);
         #1;
         chk($sformatf("alu%0d_valid", v), FW'(out_valid), FW'(5'b10000));
         chk($sformatf("alu%0d_flit", v), get_out(4), {f[FW-1 -: 16], 64'd0, vecs[v].res});
         exp_fwd++;
      end
      @(negedge clk);
      #1;
      chk("alu_fwd_count", FW'(fwd_count), FW'(exp_fwd));

      // out-of-mesh destination is discarded
      inject_one(4, mk(3, 0, 0, 0, 64'd1, 64'd1));
      #1;
      chk("drop_pulse_hi", FW'(drop_pulse), FW'(1));
      @(negedge clk);
      #1;
      chk("drop_pulse_lo", FW'(drop_pulse), FW'(0));
      chk("drop_no_out", FW'(out_valid), FW'(0));
      chk("drop_fwd_same", FW'(fwd_count), FW'(exp_fwd));

      // two heads out of mesh in the same cycle
      @(negedge clk);
      set_in(0, mk(3, 1, 0, 0, 64'd2, 64'd2));
      set_in(2, mk(0, 3, 0, 2, 64'd3, 64'd3));
      in_valid = 5'b00101;
      @(negedge clk);
      in_valid = '0;
      #1;
      chk("drop2_pulse_hi", FW'(drop_pulse), FW'(1));
      @(negedge clk);
      #1;
      chk("drop2_pulse_lo", FW'(drop_pulse), FW'(0));
      chk("drop2_in_ready", FW'(in_ready), FW'(5'h1F));
      chk("drop2_no_out", FW'(out_valid), FW'(0));

      // backpressure on E: one flit in the output register plus a full FIFO
      out_ready = 5'b11101;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         set_in(3, mk(2, 1, 0, 3, 64'(acc), 64'd0));
         in_valid[3] = 1'b1;
         #1;
         if (in_ready[3]) acc++;
      end
      @(negedge clk);
      in_valid = '0;
      #1;
      chk("bp_accepts", FW'(acc), FW'(DEPTH + 1));
      chk("bp_in_ready", FW'(in_ready[3]), FW'(0));
      chk("bp_held_valid", FW'(out_valid), FW'(5'b00010));
      chk("bp_held_flit", get_out(1), mk(2, 1, 0, 3, 64'd0, 64'd0));
      out_ready = 5'h1F;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (out_valid[1]) begin
            chk($sformatf("bp_order%0d", n), get_out(1), mk(2, 1, 0, 3, 64'(n), 64'd0));
            n++;
         end
         @(negedge clk);
      end
      exp_fwd += acc;
      chk("bp_drained", FW'(n), FW'(acc));
      chk("bp_fwd_count", FW'(fwd_count), FW'(exp_fwd));

      // reset with flits buffered
      out_ready = 5'b00000;
      for (int c = 0; c < 3; c++) begin
         set_in(3, mk(2, 1, 0, 3, 64'(100 + c), 64'd0));
         in_valid[3] = 1'b1;
         @(negedge clk);
      end
      in_valid = '0;
      #1;
      chk("pre_rst_busy", FW'(out_valid), FW'(5'b00010));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", FW'(out_valid), FW'(0));
      chk("mid_rst_in_ready", FW'(in_ready), FW'(5'h1F));
      chk("mid_rst_fwd_count", FW'(fwd_count), FW'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 5'h1F;
      exp_fwd   = 0;
      stale     = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (out_valid != 5'b0) stale++;
      end
      chk("post_rst_no_stale", FW'(stale), FW'(0));

      // N, W and L all converge on L; rr pointers fresh from reset
      traffic(12, 1'b1);
      // random traffic with random backpressure and out-of-mesh destinations
      traffic(400, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
